// File: rtl/cpu_pkg.sv
// Shared CPU front-end types and widths.
package cpu_pkg;

  localparam int unsigned XLEN    = 32;
  localparam int unsigned INSTR_W = 32;

  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = '0;

  // One prefetched instruction together with the address it was fetched from.
  typedef struct packed {
    logic [XLEN-1:0]    pc;
    logic [INSTR_W-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch queue: synchronous FIFO of fetch entries with flush and a registered head.
module fetch_fifo
  import cpu_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   flush,
  input  logic                   push,
  input  fetch_entry_t           push_data,
  input  logic                   pop,
  output fetch_entry_t           head,
  output logic [$clog2(DEPTH):0] count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  fetch_entry_t   mem [DEPTH];
  logic [AW-1:0]  rd_ptr, wr_ptr, rd_next, wr_next;
  logic [CW-1:0]  count_q, count_next, eff_count;
  fetch_entry_t   head_q, head_next;
  logic           do_pop, do_push;

  // Pointer/count update; head tracks the entry that will be at the front after this edge.
  always_comb begin
    do_pop     = pop && (count_q != '0) && !flush;
    do_push    = push && !flush;
    eff_count  = flush ? '0 : (count_q - CW'(do_pop));
    count_next = eff_count + CW'(do_push);
    rd_next    = flush ? '0 : (rd_ptr + AW'(do_pop));
    wr_next    = flush ? '0 : (wr_ptr + AW'(do_push));
    head_next  = head_q;
    if (count_next != '0) begin
      head_next = (eff_count == '0) ? push_data : mem[rd_next];
    end
  end

  // Control state; head holds its last value once the queue empties.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      count_q <= '0;
      head_q  <= '0;
    end else begin
      rd_ptr  <= rd_next;
      wr_ptr  <= wr_next;
      count_q <= count_next;
      head_q  <= head_next;
    end
  end

  // Entry storage; contents are only meaningful between rd_ptr and wr_ptr.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // Fetch throttling guarantees a slot for every response.
  always @(posedge clk) begin
    if (rst_n && do_push) begin
      assert (eff_count < CW'(DEPTH));
    end
  end

  assign head  = head_q;
  assign count = count_q;

endmodule

// File: rtl/ifetch_queue.sv
// Instruction fetch stage: PC generation, IMEM request issue, redirect handling, prefetch queue.
module ifetch_queue
  import cpu_pkg::*;
#(
  parameter int unsigned      DEPTH    = 4,
  parameter logic [XLEN-1:0]  RESET_PC = RESET_PC_DEFAULT
) (
  input  logic               clk,
  input  logic               reset,
  output logic               imem_req,
  output logic [XLEN-1:0]    imem_addr,
  input  logic [INSTR_W-1:0] imem_rdata,
  input  logic               redirect_valid,
  input  logic [XLEN-1:0]    redirect_pc,
  input  logic               halt,
  output logic               out_valid,
  output logic [INSTR_W-1:0] out_instr,
  output logic [XLEN-1:0]    out_pc,
  input  logic               out_ready,
  output logic               misalign_err
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;

  logic [XLEN-1:0] fetch_pc, resp_pc;
  logic            inflight, drop, stall;
  logic [CW-1:0]   count, occupancy;
  logic [XLEN-1:0] target;
  logic            push, pop;
  fetch_entry_t    push_data, head;

  // Request gating, response enqueue and redirect target formation.
  always_comb begin
    occupancy       = count + CW'(inflight);
    imem_req        = reset && !stall && !halt && (occupancy < CW'(DEPTH));
    target          = {redirect_pc[XLEN-1:1], 1'b0};
    push            = inflight && !drop && !redirect_valid;
    pop             = out_valid && out_ready;
    push_data.pc    = resp_pc;
    push_data.instr = imem_rdata;
  end

  // Fetch PC, in-flight tracking and redirect/misalignment state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fetch_pc     <= RESET_PC;
      resp_pc      <= RESET_PC;
      inflight     <= 1'b0;
      drop         <= 1'b0;
      stall        <= 1'b0;
      misalign_err <= 1'b0;
    end else begin
      inflight <= imem_req;
      drop     <= redirect_valid && imem_req;
      if (imem_req) begin
        resp_pc <= fetch_pc;
      end
      if (redirect_valid) begin
        if (!target[1]) begin
          fetch_pc <= target;
          stall    <= 1'b0;
        end else begin
          stall        <= 1'b1;
          misalign_err <= 1'b1;
        end
      end else if (imem_req) begin
        fetch_pc <= fetch_pc + XLEN'(4);
      end
    end
  end

  fetch_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (reset),
    .flush    (redirect_valid),
    .push     (push),
    .push_data(push_data),
    .pop      (pop),
    .head     (head),
    .count    (count)
  );

  assign imem_addr = fetch_pc;
  assign out_valid = (count != '0);
  assign out_instr = head.instr;
  assign out_pc    = head.pc;

endmodule

// File: tb/tb_ifetch_queue.sv
// Directed bench for ifetch_queue with a 1-cycle-latency IMEM model.
module tb_ifetch_queue;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        halt;
  logic        out_valid;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic        out_ready;
  logic        misalign_err;

  logic [31:0] imem [64];
  int          n_chk  = 0;
  int          n_fail = 0;

  ifetch_queue dut (
    .clk           (clk),
    .reset         (reset),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_rdata    (imem_rdata),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .halt          (halt),
    .out_valid     (out_valid),
    .out_instr     (out_instr),
    .out_pc        (out_pc),
    .out_ready     (out_ready),
    .misalign_err  (misalign_err)
  );

  always #5 clk = ~clk;

  // Synchronous IMEM: data returned the cycle after the request.
  always @(posedge clk) begin
    if (imem_req) imem_rdata <= imem[imem_addr[7:2]];
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  // Hold reset two edges, release just after an edge; returns in cycle 0.
  task automatic do_reset(input logic ready);
    reset = 1'b0; redirect_valid = 1'b0; redirect_pc = '0; halt = 1'b0; out_ready = ready;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0; redirect_valid = 1'b0; redirect_pc = '0; halt = 1'b0; out_ready = 1'b0;
    imem_rdata = '0;
    @(posedge clk); #2;
    n_chk++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL rst_req got %b exp 0", imem_req); end
    n_chk++; if (imem_addr !== 32'h0) begin n_fail++; $display("FAIL rst_addr got %h exp 0", imem_addr); end
    n_chk++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid got %b exp 0", out_valid); end
    n_chk++; if (misalign_err !== 1'b0) begin n_fail++; $display("FAIL rst_misalign got %b exp 0", misalign_err); end
    n_chk++; if (out_pc !== 32'h0) begin n_fail++; $display("FAIL rst_pc got %h exp 0", out_pc); end
    n_chk++; if (out_instr !== 32'h0) begin n_fail++; $display("FAIL rst_instr got %h exp 0", out_instr); end
  endtask

  task automatic test_stream();
    do_reset(1'b1);
    n_chk++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin n_fail++; $display("FAIL s_first_req got %b/%h exp 1/0", imem_req, imem_addr); end
    step();
    n_chk++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL s_c1_valid got %b exp 0", out_valid); end
    step();
    n_chk++; if (out_valid !== 1'b1 || out_pc !== 32'h0 || out_instr !== 32'h01000293) begin n_fail++; $display("FAIL s_c2 got %b %h %h exp 1 0 01000293", out_valid, out_pc, out_instr); end
    step();
    n_chk++; if (out_valid !== 1'b1 || out_pc !== 32'h4 || out_instr !== 32'h000280E7) begin n_fail++; $display("FAIL s_c3 got %b %h %h exp 1 4 000280e7", out_valid, out_pc, out_instr); end
    step();
    n_chk++; if (out_valid !== 1'b1 || out_pc !== 32'h8 || out_instr !== 32'h06300393) begin n_fail++; $display("FAIL s_c4 got %b %h %h exp 1 8 06300393", out_valid, out_pc, out_instr); end
  endtask

  task automatic test_backpressure();
    logic [31:0] exp_pc;
    do_reset(1'b0);
    repeat (3) step();
    n_chk++; if (imem_req !== 1'b1 || imem_addr !== 32'hC) begin n_fail++; $display("FAIL bp_c3_req got %b/%h exp 1/c", imem_req, imem_addr); end
    step();
    n_chk++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL bp_c4_req got %b exp 0", imem_req); end
    step();
    n_chk++; if (imem_req !== 1'b0 || out_pc !== 32'h0 || out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_c5 got %b %h %b exp 0 0 1", imem_req, out_pc, out_valid); end
    step();
    out_ready = 1'b1; #1;
    n_chk++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL bp_pop_no_free got %b exp 0", imem_req); end
    for (int i = 0; i < 5; i++) begin
      exp_pc = 32'(4 * i);
      n_chk++; if (out_valid !== 1'b1 || out_pc !== exp_pc) begin n_fail++; $display("FAIL bp_drain%0d got %b %h exp 1 %h", i, out_valid, out_pc, exp_pc); end
      step();
    end
  endtask

  task automatic test_redirect();
    do_reset(1'b0);
    repeat (4) step();
    n_chk++; if (imem_req !== 1'b0 || out_pc !== 32'h0) begin n_fail++; $display("FAIL rd_pre got %b %h exp 0 0", imem_req, out_pc); end
    redirect_valid = 1'b1; redirect_pc = 32'h10;
    step();
    redirect_valid = 1'b0; #1;
    n_chk++; if (out_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h10) begin n_fail++; $display("FAIL rd_c1 got %b %b %h exp 0 1 10", out_valid, imem_req, imem_addr); end
    step();
    n_chk++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rd_c2_valid got %b exp 0", out_valid); end
    step();
    n_chk++; if (out_valid !== 1'b1 || out_pc !== 32'h10 || out_instr !== 32'h02A00313) begin n_fail++; $display("FAIL rd_c3 got %b %h %h exp 1 10 02a00313", out_valid, out_pc, out_instr); end
    out_ready = 1'b1;
    step();
    n_chk++; if (out_valid !== 1'b1 || out_pc !== 32'h14 || out_instr !== 32'h10000005) begin n_fail++; $display("FAIL rd_c4 got %b %h %h exp 1 14 10000005", out_valid, out_pc, out_instr); end
  endtask

  task automatic test_halt();
    do_reset(1'b1);
    repeat (3) step();
    halt = 1'b1; #1;
    n_chk++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL h_req got %b exp 0", imem_req); end
    n_chk++; if (out_pc !== 32'h4) begin n_fail++; $display("FAIL h_c3_pc got %h exp 4", out_pc); end
    step();
    n_chk++; if (out_valid !== 1'b1 || out_pc !== 32'h8) begin n_fail++; $display("FAIL h_inflight got %b %h exp 1 8", out_valid, out_pc); end
    step();
    n_chk++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL h_drained got %b exp 0", out_valid); end
    step();
    n_chk++; if (out_valid !== 1'b0 || imem_req !== 1'b0) begin n_fail++; $display("FAIL h_idle got %b %b exp 0 0", out_valid, imem_req); end
    halt = 1'b0; #1;
    n_chk++; if (imem_req !== 1'b1 || imem_addr !== 32'hC) begin n_fail++; $display("FAIL h_resume got %b %h exp 1 c", imem_req, imem_addr); end
    step(); step();
    n_chk++; if (out_valid !== 1'b1 || out_pc !== 32'hC) begin n_fail++; $display("FAIL h_resume_data got %b %h exp 1 c", out_valid, out_pc); end
  endtask

  task automatic test_misalign();
    do_reset(1'b1);
    repeat (2) step();
    redirect_valid = 1'b1; redirect_pc = 32'h11;
    step();
    redirect_valid = 1'b0; #1;
    n_chk++; if (imem_req !== 1'b1 || imem_addr !== 32'h10 || misalign_err !== 1'b0) begin n_fail++; $display("FAIL ma_bit0 got %b %h %b exp 1 10 0", imem_req, imem_addr, misalign_err); end
    n_chk++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL ma_flush got %b exp 0", out_valid); end
    step();
    n_chk++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL ma_drop got %b %h exp 0", out_valid, out_pc); end
    step();
    n_chk++; if (out_valid !== 1'b1 || out_pc !== 32'h10 || out_instr !== 32'h02A00313) begin n_fail++; $display("FAIL ma_target got %b %h %h exp 1 10 02a00313", out_valid, out_pc, out_instr); end
    redirect_valid = 1'b1; redirect_pc = 32'h16;
    step();
    redirect_valid = 1'b0; #1;
    n_chk++; if (misalign_err !== 1'b1) begin n_fail++; $display("FAIL ma_err got %b exp 1", misalign_err); end
    for (int i = 0; i < 4; i++) begin
      n_chk++; if (imem_req !== 1'b0 || out_valid !== 1'b0) begin n_fail++; $display("FAIL ma_stall%0d got %b %b exp 0 0", i, imem_req, out_valid); end
      step();
    end
    redirect_valid = 1'b1; redirect_pc = 32'h8;
    step();
    redirect_valid = 1'b0; #1;
    n_chk++; if (imem_req !== 1'b1 || imem_addr !== 32'h8 || misalign_err !== 1'b1) begin n_fail++; $display("FAIL ma_resume got %b %h %b exp 1 8 1", imem_req, imem_addr, misalign_err); end
    step(); step();
    n_chk++; if (out_valid !== 1'b1 || out_pc !== 32'h8 || out_instr !== 32'h06300393) begin n_fail++; $display("FAIL ma_resume_data got %b %h %h exp 1 8 06300393", out_valid, out_pc, out_instr); end
  endtask

  // Continues from the misaligned, actively fetching state left by test_misalign.
  task automatic test_async_reset();
    #2 reset = 1'b0;
    #1;
    n_chk++; if (out_valid !== 1'b0 || imem_req !== 1'b0 || misalign_err !== 1'b0) begin n_fail++; $display("FAIL ar_clear got %b %b %b exp 0 0 0", out_valid, imem_req, misalign_err); end
    n_chk++; if (imem_addr !== 32'h0) begin n_fail++; $display("FAIL ar_addr got %h exp 0", imem_addr); end
    #1 reset = 1'b1;
    #1;
    n_chk++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin n_fail++; $display("FAIL ar_first_req got %b %h exp 1 0", imem_req, imem_addr); end
    step(); step();
    n_chk++; if (out_valid !== 1'b1 || out_pc !== 32'h0 || out_instr !== 32'h01000293) begin n_fail++; $display("FAIL ar_first_data got %b %h %h exp 1 0 01000293", out_valid, out_pc, out_instr); end
  endtask

  initial begin
    for (int i = 0; i < 64; i++) imem[i] = 32'h1000_0000 + 32'(i);
    imem[0] = 32'h01000293;
    imem[1] = 32'h000280E7;
    imem[2] = 32'h06300393;
    imem[4] = 32'h02A00313;
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect();
    test_halt();
    test_misalign();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/ifetch_queue.md
Name: ifetch_queue

Overview:
Instruction fetch stage directly upstream of the cpu decode/execute path.
- Owns the fetch PC and issues word reads to the synchronous instruction memory (IMEM, 1-cycle read latency).
- Buffers returned instructions with their PCs in a small prefetch queue.
- Presents them to the core over a valid/ready interface.
- Handles control-flow redirects (jal/jalr targets) by flushing the queue and dropping stale in-flight reads.

Parameters:
DEPTH, 4, prefetch queue entries (power of 2, >=2)
XLEN, 32, address/instruction width
RESET_PC, 0, fetch address after reset

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low reset (0 = in reset)
imem_req  out  1  read request this cycle
imem_addr  out  XLEN  byte address of request (word aligned)
imem_rdata  in  32  read data, valid the cycle after imem_req
redirect_valid  in  1  control-flow redirect from core
redirect_pc  in  XLEN  redirect target
halt  in  1  stop issuing new fetches
out_valid  out  1  queue head valid
out_instr  out  32  head instruction
out_pc  out  XLEN  head PC
out_ready  in  1  core accepts head
misalign_err  out  1  sticky: redirect target not 4-byte aligned

Behaviour:
Reset (reset=0, async):
- count=0, inflight=0, drop=0, fetch_pc=RESET_PC, misalign_err=0, stall=0.
- All outputs 0 except imem_addr=RESET_PC.
- An in-flight read at reset assertion is discarded.

Request issue:
- imem_req = !stall && !halt && (count + inflight < DEPTH), using the current-cycle count; a same-cycle pop does not free a slot.
- imem_addr = fetch_pc (combinational from register).
- On issue, fetch_pc += 4 (mod 2^XLEN wrap) and inflight=1 next cycle.

Response:
- In the cycle after a request, imem_rdata is enqueued with its PC at the clock edge, unless drop=1.
- out_valid rises the following cycle, i.e. 2 cycles from imem_req to out_valid.

Dequeue:
- Pop when out_valid && out_ready.
- Push and pop in the same cycle keeps count unchanged.
- Push when full cannot occur by construction; assert this in simulation.

Redirect (sampled at edge):
- Flushes the queue: count=0, out_valid=0 next cycle.
- Sets drop=1 if a response is due next cycle.
- Effective target = redirect_pc with bit0 cleared (jalr semantics).
- If target bit1=0: fetch_pc=target, stall=0. The first request is next cycle, and out_valid is 3 cycles after the redirect cycle.
- If target bit1=1: misalign_err=1 (sticky until reset), stall=1, no requests issued until an aligned redirect.

Priority:
- reset > redirect > push/pop.
- A redirect in the same cycle as a pop: the pop is a don't-care because the queue is flushed. Any request issued in the redirect cycle uses the old fetch_pc and is dropped.

Halt:
- Blocks new requests only.
- An in-flight response is still enqueued, and the queue continues to drain.
- Deasserting halt resumes fetch at fetch_pc.

Outputs when empty:
- out_instr/out_pc hold the last value.
- The core must qualify them with out_valid.

Decomposition:
- cpu_pkg holds: XLEN, INSTR_W=32, default RESET_PC, and typedef fetch_entry_t {pc, instr}.
- Natural sub-module: fetch_fifo.
  - Synchronous FIFO of fetch_entry_t with flush input, count output, async active-low reset.
  - Queue storage lives there.
  - PC, inflight/drop and redirect logic stay in ifetch_queue.

Test Plan:
1. IMEM words 0x01000293,0x000280E7,0x06300393 at 0,4,8; out_ready=1 from reset release.
   -> imem_req=1 addr 0 first cycle; out_valid at cycle 2 with out_pc=0, out_instr=0x01000293; then pc 4,8 on consecutive cycles.
2. out_ready=0 after reset.
   -> exactly 4 entries (pc 0..12) queued; imem_req drops once count+inflight=4; head stays pc 0.
   -> raising out_ready drains one per cycle with no gaps.
3. Queue holding pc 0..8 with a read in flight; redirect_pc=16 for one cycle.
   -> out_valid=0 next cycle; the stale pc-12 response is not delivered.
   -> out_pc=16, out_instr=0x02A00313 is the next delivered entry, 3 cycles after the redirect.
4. redirect_pc=0x11 -> fetch from 0x10, misalign_err stays 0.
   redirect_pc=0x16 -> misalign_err=1, imem_req=0 indefinitely.
   Subsequent redirect_pc=8 -> fetch resumes at 8, misalign_err still 1.
5. halt=1 during steady fetch.
   -> imem_req=0 same cycle; the in-flight word is still delivered; queue drains to out_valid=0.
   halt=0 -> the next fetch address continues sequentially.
6. Assert reset mid-fill between clock edges.
   -> out_valid, imem_req, misalign_err go 0 without a clock edge.
   -> after release the first request is at RESET_PC.
